// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_pkg
// Description : Shared widths, feeder state encoding and SHA-256 constants.
// Revision    : 1.0  initial release
// ============================================================================
package sha_pkg;

    localparam int MSG_W        = 1024;
    localparam int HDR_PREFIX_W = 608;
    localparam int NONCE_W      = 32;

    localparam logic [63:0] PAD_LEN_640 = 64'h0000_0000_0000_0280;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } feeder_state_e;

    // Initial hash value H0..H7, H0 in the most significant word.
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage
`default_nettype wire

// File: rtl/bitcoin_pad_assemble.sv
`default_nettype none
// ============================================================================
// Module      : bitcoin_pad_assemble
// Description : Combinational build of the padded 80-byte header message.
// Revision    : 1.0  initial release
// ============================================================================
module bitcoin_pad_assemble
    import sha_pkg::*;
#(
    parameter int NONCE_LE = 1
)
(
    input  logic [HDR_PREFIX_W-1:0] prefix_i,
    input  logic [NONCE_W-1:0]      nonce_i,
    output logic [MSG_W-1:0]        message_o
);

    logic [NONCE_W-1:0] w_nonce_field;

    generate
        if (NONCE_LE != 0) begin : g_nonce_swap
            assign w_nonce_field = {nonce_i[7:0], nonce_i[15:8], nonce_i[23:16], nonce_i[31:24]};
        end else begin : g_nonce_raw
            assign w_nonce_field = nonce_i;
        end
    endgenerate

    // 608 + 32 + 1 + 319 + 64 = 1024: header, nonce, pad bit, zeros, bit length.
    assign message_o = {prefix_i, w_nonce_field, 1'b1, 319'd0, PAD_LEN_640};

endmodule
`default_nettype wire

// File: rtl/nonce_message_feeder.sv
`default_nettype none
// ============================================================================
// Module      : nonce_message_feeder
// Description : Iterates a nonce range and hands padded messages downstream.
// Revision    : 1.0  initial release
// ============================================================================
module nonce_message_feeder
    import sha_pkg::*;
#(
    parameter int GAP_CYCLES = 15,
    parameter int NONCE_LE   = 1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [HDR_PREFIX_W-1:0] header_prefix_i,
    input  logic [NONCE_W-1:0]      nonce_start_i,
    input  logic [NONCE_W-1:0]      nonce_end_i,
    input  logic                    msg_ready_i,
    output logic [MSG_W-1:0]        message_o,
    output logic                    msg_valid_o,
    output logic [NONCE_W-1:0]      cur_nonce_o,
    output logic [NONCE_W:0]        sent_count_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    feeder_state_e           state_q;
    logic [HDR_PREFIX_W-1:0] prefix_q;
    logic [NONCE_W-1:0]      nonce_end_q;
    logic [NONCE_W-1:0]      cur_nonce_q;
    logic [NONCE_W:0]        sent_count_q;
    logic [MSG_W-1:0]        message_q;
    logic                    msg_valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [c_GAP_W-1:0]      gap_cnt_q;

    logic [MSG_W-1:0]        w_message;
    logic                    w_accept;

    bitcoin_pad_assemble #(
        .NONCE_LE (NONCE_LE)
    ) u_pad (
        .prefix_i  (prefix_q),
        .nonce_i   (cur_nonce_q),
        .message_o (w_message)
    );

    assign w_accept = msg_valid_q & msg_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prefix_q     <= '0;
            nonce_end_q  <= '0;
            cur_nonce_q  <= '0;
            sent_count_q <= '0;
            message_q    <= '0;
            msg_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            gap_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        prefix_q     <= header_prefix_i;
                        nonce_end_q  <= nonce_end_i;
                        cur_nonce_q  <= nonce_start_i;
                        sent_count_q <= '0;
                        busy_q       <= 1'b1;
                        if (nonce_start_i > nonce_end_i) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (stop_i) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        message_q   <= w_message;
                        msg_valid_q <= 1'b1;
                        state_q     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (w_accept) begin
                        sent_count_q <= sent_count_q + 33'd1;
                        msg_valid_q  <= 1'b0;
                        // End test precedes the increment so an all-ones end never wraps.
                        if (stop_i || (cur_nonce_q == nonce_end_q)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            cur_nonce_q <= cur_nonce_q + 32'd1;
                            gap_cnt_q   <= '0;
                            state_q     <= (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;
                        end
                    end else if (stop_i) begin
                        msg_valid_q <= 1'b0;
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (stop_i) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q == c_GAP_LAST) begin
                        state_q <= ST_LOAD;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    msg_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign message_o    = message_q;
    assign msg_valid_o  = msg_valid_q;
    assign cur_nonce_o  = cur_nonce_q;
    assign sent_count_o = sent_count_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: doc/nonce_message_feeder.md
Name: nonce_message_feeder

Overview:
- Upstream stage of the two-block SHA-256 message scheduler/compressor.
- Latches a 76-byte Bitcoin header prefix and a nonce range, then iterates the nonce.
- For each nonce, it builds the 1024-bit padded message (80-byte header + SHA-256 padding) and presents it to the downstream stage through a valid/ready handshake.
- Reports progress, supports early stop, and signals completion.

Parameters:
- GAP_CYCLES, 15: idle cycles between an accepted message and the next LOAD; 0 means back-to-back. Matches the downstream settling delay.
- NONCE_LE, 1: 1 places the nonce byte-swapped (Bitcoin little-endian wire order); 0 places it as-is.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- stop  in  1  abort request; honoured in any non-IDLE state.
- header_prefix  in  608  version|prev_hash|merkle_root|time|bits, bit 607 = first header bit.
- nonce_start  in  32  first nonce, latched on start.
- nonce_end  in  32  last nonce (inclusive), latched on start.
- msg_ready  in  1  downstream accepts message this cycle.
- message  out  1024  padded two-block message.
- msg_valid  out  1  message valid.
- cur_nonce  out  32  nonce of the message currently held.
- sent_count  out  33  number of messages accepted this run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: state=IDLE, message=0, msg_valid=0, cur_nonce=0, sent_count=0, busy=0, done=0. Reset mid-run aborts immediately with no done pulse.
- Message layout:
  - message[1023:416] = header_prefix.
  - message[415:384] = nonce (byte-swapped if NONCE_LE).
  - message[383] = 1; message[382:64] = 0.
  - message[63:0] = 64'h0000_0000_0000_0280 (640-bit length).
- FSM states: IDLE, LOAD, PRESENT, GAP, DONE.
- IDLE:
  - start=1 → latch prefix/start/end, cur_nonce=nonce_start, sent_count=0, go LOAD.
  - If nonce_start > nonce_end → go DONE instead (zero messages).
- LOAD: register the assembled message (one cycle); go PRESENT with msg_valid=1 on the next cycle. Latency from start to first msg_valid = 2 cycles.
- PRESENT:
  - message and cur_nonce are held stable while msg_valid=1 and msg_ready=0.
  - Accept = msg_valid & msg_ready. On accept: sent_count+1, msg_valid=0.
  - Then, if cur_nonce==nonce_end → DONE; else cur_nonce+1 and go GAP (or LOAD directly if GAP_CYCLES=0).
- GAP: count GAP_CYCLES cycles, then go LOAD.
- DONE: done=1 for exactly one cycle, msg_valid=0, then IDLE (busy=0 in IDLE).
- Range end / wrap: the end comparison is made before incrementing, so nonce_end=32'hFFFFFFFF terminates without wrapping to 0. sent_count is 33 bits, so the full range (2^32) is representable.
- stop:
  - From LOAD, GAP or PRESENT without accept → DONE next cycle; msg_valid drops immediately.
  - stop and accept in the same cycle → the accept counts (sent_count increments), then DONE.
  - stop in IDLE or DONE is ignored.
- start while busy is ignored; latched inputs are not re-sampled mid-run.
- start and stop in the same IDLE cycle → start wins; the stop is discarded.
- msg_valid never deasserts without an accept, except on stop or rst.

Decomposition:
- Package sha_pkg holds:
  - MSG_W=1024, HDR_PREFIX_W=608, NONCE_W=32.
  - PAD_LEN_640=64'h280.
  - The feeder state enum.
  - The SHA-256 IV and K constants, for sharing with the scheduler.
- Sub-module bitcoin_pad_assemble (combinational) takes prefix and nonce and produces the 1024-bit message, including the NONCE_LE swap. The FSM registers its output in LOAD.

Test Plan:
- Reset check: assert rst for 3 cycles mid-PRESENT → next cycle all outputs 0, state IDLE, no done pulse.
- Single nonce: prefix=all 0x01 bytes, start=end=32'h12345678, NONCE_LE=1, msg_ready=1 → expected response:
  - message[415:384]=32'h78563412, message[383:376]=8'h80, message[63:0]=64'h280.
  - sent_count=1; done pulses once; msg_valid high for exactly 1 cycle.
- Backpressure: range 5..7, GAP_CYCLES=2, msg_ready low for 10 cycles on each message → expected response:
  - message stable while stalled.
  - cur_nonce sequence 5,6,7; sent_count=3.
  - Exactly 2 GAP cycles between accept and the next LOAD.
- Top of range: start=32'hFFFFFFFE, end=32'hFFFFFFFF → 2 messages, cur_nonce never 0, done after the second accept.
- Empty range: start=10, end=9 → no msg_valid, done 1 cycle after start, sent_count=0.
- Stop races: stop in GAP → done next cycle, no further msg_valid. stop coincident with accept on nonce 3 of range 0..9 → sent_count=4, then done.
